uart_rx_b: RTL and testbench
============================

UART_RX_B -- requirements
Module: uart_rx_b

Interface
REQ-001 Parameter KBAUD, default 14'd10416, baud divider; one bit period = KBAUD+1 clk cycles, matching the transmitter's bit timing.
REQ-002 Parameter CNT_BITS, default $clog2(KBAUD), width of the baud counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 IN  input  1  serial line; idles high; format 8N1, LSB first.
REQ-006 data  output  8  last correctly framed received byte.
REQ-007 Rx_done  output  1  one-cycle pulse: data holds a new valid byte.
REQ-008 Rx_busy  output  1  high from accepted start edge until return to IDLE.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 baud_clk_wi  output  CNT_BITS  live baud counter value, for debug.

Function
REQ-011 IN SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized line, rx_s.
REQ-012 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: baud counter held at 0; a high-to-low transition on rx_s SHALL move to START and clear the counter.
REQ-014 START: at counter == KBAUD/2 (integer floor), rx_s low -> DATA with counter cleared; rx_s high -> false start, back to IDLE; no output pulse.
REQ-015 DATA: at each counter == KBAUD, sample rx_s into bit index 0..7 (LSB first), then clear the counter; after bit 7 -> STOP.
REQ-016 Mid-bit sampling: each data and stop sample SHALL fall (KBAUD+1)/2 +/-1 cycles after the nominal bit start.
REQ-017 The counter SHALL count 0..KBAUD and wrap to 0; it never exceeds KBAUD.
REQ-018 Received bits SHALL go into an internal shift register; data SHALL change only on a valid stop bit.
REQ-019 STOP, at counter == KBAUD: rx_s high -> load data, pulse Rx_done for one cycle, go to IDLE.
REQ-020 STOP, at counter == KBAUD: rx_s low -> pulse frame_err for one cycle, leave data unchanged, go to WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until rx_s is high, then go to IDLE; a low line (break) SHALL NOT trigger a new frame.
REQ-022 Back-to-back frames: a start edge in the cycle after Rx_done SHALL be accepted with no bits lost.
REQ-023 Rx_done and frame_err SHALL never be high in the same cycle.
REQ-024 Rx_busy SHALL be high in START, DATA, STOP and WAIT_IDLE, and low in IDLE.
REQ-025 Rx_done SHALL assert 9.5 bit periods +/-3 cycles after the falling edge on IN.
REQ-026 The illegal state encoding SHALL recover to IDLE on the next clock.

Reset
REQ-027 While rst is low: state IDLE, counter 0, shift register 0, data 8'h00, Rx_done 0, frame_err 0, Rx_busy 0, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no Rx_done or frame_err pulse.
REQ-029 After reset release, a frame SHALL be received only after a new falling edge on IN; a line already low SHALL NOT start a frame.

Verification
REQ-030 KBAUD=15; drive 8N1 byte 8'hA5 on IN -> exactly one Rx_done pulse; data=8'hA5; frame_err never high.
REQ-031 KBAUD=15; two back-to-back frames 8'h00 then 8'hFF with no idle gap -> two Rx_done pulses; data=8'h00, then 8'hFF.
REQ-032 KBAUD=15; low glitch on IN of 4 cycles -> Rx_busy rises then falls; no Rx_done; data unchanged.
REQ-033 KBAUD=15; byte 8'h3C with stop bit low -> frame_err pulse; data keeps its old value; with IN held low a further 40 cycles, no new frame starts.
REQ-034 KBAUD=15; rst pulsed low at bit 4 of a frame -> all outputs at reset values; then frame 8'h5A -> data=8'h5A.
REQ-035 Loopback with the transmitter (same KBAUD): bytes 8'h00..8'hFF -> every byte received intact, in order.

Source files
------------

// File: rtl/uart_rx_b.sv
// 8N1 UART receiver: 2-flop input synchronizer, start-edge detect, mid-bit sampling,
// registered Rx_done / frame_err pulses and a break-tolerant WAIT_IDLE state.
module uart_rx_b #(
  parameter int unsigned KBAUD    = 14'd10416,
  parameter int unsigned CNT_BITS = $clog2(KBAUD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IN,
  output logic [7:0]          data,
  output logic                Rx_done,
  output logic                Rx_busy,
  output logic                frame_err,
  output logic [CNT_BITS-1:0] baud_clk_wi
);

  localparam logic [CNT_BITS-1:0] KMAX  = CNT_BITS'(KBAUD);
  localparam logic [CNT_BITS-1:0] KHALF = CNT_BITS'(KBAUD / 2);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } state_e;

  state_e              state;
  logic [CNT_BITS-1:0] cnt;
  logic [7:0]          shreg;
  logic [2:0]          bit_idx;
  logic                rx_meta;
  logic                rx_s;
  logic                rx_prev;
  logic [1:0]          sync_vld;
  logic                fall;

  // rx_prev only follows rx_s once the synchronizer holds real line samples, so the
  // reset value of the chain cannot fake a start edge on a line that is already low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b0;
      sync_vld <= 2'b00;
    end else begin
      rx_meta  <= IN;
      rx_s     <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      rx_prev  <= sync_vld[1] ? rx_s : 1'b0;
    end
  end

  assign fall        = rx_prev & ~rx_s;
  assign baud_clk_wi = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      cnt       <= '0;
      shreg     <= 8'h00;
      bit_idx   <= 3'd0;
      data      <= 8'h00;
      Rx_done   <= 1'b0;
      frame_err <= 1'b0;
      Rx_busy   <= 1'b0;
    end else begin
      Rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        StIdle: begin
          cnt <= '0;
          if (fall) begin
            state   <= StStart;
            Rx_busy <= 1'b1;
          end
        end
        StStart: begin
          if (cnt == KHALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= StData;
              bit_idx <= 3'd0;
            end else begin
              state   <= StIdle;
              Rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        StData: begin
          if (cnt == KMAX) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= StStop;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        StStop: begin
          if (cnt == KMAX) begin
            cnt <= '0;
            if (rx_s) begin
              data    <= shreg;
              Rx_done <= 1'b1;
              state   <= StIdle;
              Rx_busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= StWaitIdle;
            end
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        StWaitIdle: begin
          cnt <= '0;
          if (rx_s) begin
            state   <= StIdle;
            Rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= StIdle;
          cnt     <= '0;
          Rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_b.sv
// Bench for uart_rx_b at KBAUD=15: vector table, corner sequences, random frames and
// a full 0x00..0xFF loopback checked against an expected-byte queue.
module tb_uart_rx_b;

  localparam int unsigned KB   = 15;
  localparam int          P    = KB + 1;
  localparam int          PER  = 10;
  localparam int          HALF = PER / 2;

  logic       clk;
  logic       rst;
  logic       in_line;
  logic [7:0] data;
  logic       rx_done;
  logic       rx_busy;
  logic       ferr;
  logic [3:0] baud;

  uart_rx_b #(.KBAUD(KB)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN          (in_line),
    .data        (data),
    .Rx_done     (rx_done),
    .Rx_busy     (rx_busy),
    .frame_err   (ferr),
    .baud_clk_wi (baud)
  );

  initial clk = 1'b0;
  always #(HALF) clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor state
  int         n_done    = 0;
  int         n_ferr    = 0;
  int         n_both    = 0;
  int         n_rise    = 0;
  logic       busy_prev = 1'b0;
  logic [3:0] max_cnt   = 4'd0;
  time        t_done    = 0;
  logic [7:0] got_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rx_done) begin
        n_done++;
        got_q.push_back(data);
        t_done = $time;
      end
      if (ferr) n_ferr++;
      if (rx_done && ferr) n_both++;
      if (rx_busy && !busy_prev) n_rise++;
      busy_prev = rx_busy;
      if (baud > max_cnt) max_cnt = baud;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    in_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    in_line = v;
    repeat (P) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         hold_low;
    int         idle_after;
    logic       exp_done;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         d0, f0, r0;
    time        ts, elapsed;
    logic [7:0] rb;
    logic       rs;
    int         exp_ferr;
    logic [7:0] exp_q[$];

    vecs[0] = '{8'hA5, 1'b1, 0,  20, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,  0,  1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,  20, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 40, 20, 1'b0, 1'b1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 0,  5,  1'b1, 1'b0, 8'h81};
    vecs[5] = '{8'h7E, 1'b0, 0,  20, 1'b0, 1'b1, 8'h81};
    vecs[6] = '{8'h01, 1'b1, 0,  20, 1'b1, 1'b0, 8'h01};

    rst     = 1'b0;
    in_line = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_done", 32'(rx_done), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    check("rst_baud", 32'(baud), 32'h0);
    rst = 1'b1;
    idle(10);

    for (int i = 0; i < 7; i++) begin
      d0 = n_done;
      f0 = n_ferr;
      r0 = n_rise;
      ts = $time;
      send_frame(vecs[i].b, vecs[i].stop);
      if (vecs[i].hold_low > 0) begin
        in_line = 1'b0;
        repeat (vecs[i].hold_low) @(negedge clk);
        check($sformatf("v%0d_break_busy", i), 32'(rx_busy), 32'h1);
      end
      check($sformatf("v%0d_done", i), 32'(n_done - d0), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_starts", i), 32'(n_rise - r0), 32'h1);
      if (vecs[i].exp_done) begin
        elapsed = t_done - HALF - ts;
        check($sformatf("v%0d_latency", i),
              32'(elapsed >= time'(149 * PER) && elapsed <= time'(155 * PER)), 32'h1);
      end
      idle(vecs[i].idle_after);
      if (vecs[i].idle_after >= 5) check($sformatf("v%0d_idle_busy", i), 32'(rx_busy), 32'h0);
    end

    // Short low glitch: false start, nothing received.
    d0 = n_done;
    r0 = n_rise;
    in_line = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("glitch_rise", 32'(n_rise - r0), 32'h1);
    check("glitch_busy", 32'(rx_busy), 32'h0);
    check("glitch_done", 32'(n_done - d0), 32'h0);
    check("glitch_data", 32'(data), 32'h01);

    // Reset in the middle of bit 4 of 0xC3 (a 0 bit), line left low across release.
    d0 = n_done;
    f0 = n_ferr;
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(rb_c3(k));
    in_line = 1'b0;
    repeat (P / 2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_busy", 32'(rx_busy), 32'h0);
    check("mid_rst_baud", 32'(baud), 32'h0);
    rst = 1'b1;
    r0 = n_rise;
    repeat (40) @(negedge clk);
    check("low_after_rst_busy", 32'(rx_busy), 32'h0);
    check("low_after_rst_rise", 32'(n_rise - r0), 32'h0);
    check("mid_rst_no_pulses", 32'((n_done - d0) + (n_ferr - f0)), 32'h0);
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("post_rst_data", 32'(data), 32'h5A);
    check("post_rst_done", 32'(n_done - d0), 32'h1);

    // Random frames against an expected-byte queue.
    got_q.delete();
    exp_q.delete();
    exp_ferr = 0;
    f0 = n_ferr;
    for (int k = 0; k < 40; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rb, rs);
      if (rs) begin
        exp_q.push_back(rb);
        idle($urandom_range(0, 12));
      end else begin
        exp_ferr++;
        in_line = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clk);
        idle($urandom_range(2, 12));
      end
    end
    idle(20);
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    check("rand_ferr", 32'(n_ferr - f0), 32'(exp_ferr));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rand_byte%0d", k), 32'(got_q[k]), 32'(exp_q[k]));

    // Back-to-back loopback of every byte value.
    got_q.delete();
    for (int k = 0; k < 256; k++) send_frame(8'(k), 1'b1);
    idle(20);
    check("loop_count", 32'(got_q.size()), 32'd256);
    for (int k = 0; k < 256 && k < got_q.size(); k++)
      check($sformatf("loop_byte%0d", k), 32'(got_q[k]), 32'(k));

    check("never_both", 32'(n_both), 32'h0);
    check("baud_max", 32'(max_cnt), 32'(KB));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic rb_c3(input int k);
    logic [7:0] v;
    v = 8'hC3;
    return v[k];
  endfunction

endmodule
